// File: rtl/cve2_rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI retirement trace buffer.
package cve2_rvfi_trace_buffer_pkg;

  // One captured retirement; order is truncated to its low 16 bits.
  typedef struct packed {
    logic [15:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
    logic        trig;
  } trace_entry_t;

  typedef enum logic [1:0] {
    TB_IDLE   = 2'd0,
    TB_ARMED  = 2'd1,
    TB_POST   = 2'd2,
    TB_FROZEN = 2'd3
  } trace_buf_state_e;

endpackage

// File: rtl/cve2_trace_ring.sv
// Circular flop-array store: push overwrites the oldest entry when full,
// pop removes the oldest, clr empties it. Head is read combinationally.
module cve2_trace_ring
  import cve2_rvfi_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr,
  input  logic                     push,
  input  trace_entry_t             push_data,
  input  logic                     pop,
  output trace_entry_t             head,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] Full = LvlW'(Depth);

  trace_entry_t    mem [Depth];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic            full;

  assign full = (level == Full);
  assign head = mem[rptr];

  // Storage array; contents need no reset because the level qualifies them.
  always_ff @(posedge clk_i) begin
    if (push && !clr) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers and occupancy; a push into a full ring drags the read pointer along.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop || (push && full)) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop && !full) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// Post-mortem RVFI capture: records retirements while armed, keeps a fixed
// number after a trigger, then freezes and drains oldest-first.
module cve2_rvfi_trace_buffer
  import cve2_rvfi_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth         = 16,
  parameter int unsigned PostTrigCount = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_insn,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic                     arm_i,
  input  logic                     trig_i,
  input  logic                     trig_on_trap_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output trace_entry_t             rd_entry_o,
  output logic [1:0]               state_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [15:0]              dropped_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] PostCnt = CntW'(PostTrigCount);

  trace_buf_state_e state;
  logic [CntW-1:0]  post_cnt;
  logic [CntW-1:0]  post_inc;
  logic             trigger;
  logic             push;
  logic             pop;
  logic             capturing;
  trace_entry_t     push_data;
  trace_entry_t     head;
  logic             unused_order;

  assign unused_order = ^rvfi_order[63:16];

  // Event decode; arm_i masks every other event in its cycle.
  always_comb begin
    capturing  = (state == TB_ARMED) || (state == TB_POST);
    trigger    = trig_i || (trig_on_trap_i && rvfi_valid && rvfi_trap);
    rd_valid_o = (state == TB_FROZEN) && (level_o != '0);
    push       = !arm_i && rvfi_valid && capturing;
    pop        = !arm_i && rd_valid_o && rd_ready_i;
    post_inc   = post_cnt + 1'b1;
    rd_entry_o = rd_valid_o ? head : '0;
    push_data  = '{
      order:    rvfi_order[15:0],
      pc:       rvfi_pc_rdata,
      insn:     rvfi_insn,
      rd_addr:  rvfi_rd_addr,
      rd_wdata: rvfi_rd_wdata,
      trap:     rvfi_trap,
      intr:     rvfi_intr,
      trig:     (state == TB_ARMED) && trigger
    };
  end

  cve2_trace_ring #(
    .Depth (Depth)
  ) u_ring (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr       (arm_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .level     (level_o)
  );

  assign state_o = state;

  // Capture controller: state, post-trigger count and saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= TB_IDLE;
      post_cnt  <= '0;
      dropped_o <= '0;
    end else if (arm_i) begin
      state     <= TB_ARMED;
      post_cnt  <= '0;
      dropped_o <= '0;
    end else begin
      case (state)
        TB_ARMED: begin
          if (trigger) begin
            post_cnt <= '0;
            state    <= (PostTrigCount == 0) ? TB_FROZEN : TB_POST;
          end
        end
        TB_POST: begin
          if (rvfi_valid) begin
            post_cnt <= post_inc;
            if (post_inc == PostCnt) begin
              state <= TB_FROZEN;
            end
          end
        end
        default: begin
          if (rvfi_valid && (dropped_o != 16'hFFFF)) begin
            dropped_o <= dropped_o + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Bench for the RVFI trace buffer: queue-based model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_cve2_rvfi_trace_buffer;
  import cve2_rvfi_trace_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int PTC   = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         rvfi_valid;
  logic [63:0]  rvfi_order;
  logic [31:0]  rvfi_insn;
  logic [31:0]  rvfi_pc_rdata;
  logic         rvfi_trap;
  logic         rvfi_intr;
  logic [4:0]   rvfi_rd_addr;
  logic [31:0]  rvfi_rd_wdata;
  logic         arm_i;
  logic         trig_i;
  logic         trig_on_trap_i;
  logic         rd_ready_i;
  logic         rd_valid_o;
  trace_entry_t rd_entry_o;
  logic [1:0]   state_o;
  logic [4:0]   level_o;
  logic [15:0]  dropped_o;

  logic         z_rd_valid;
  trace_entry_t z_rd_entry;
  logic [1:0]   z_state;
  logic [4:0]   z_level;
  logic [15:0]  z_dropped;

  int total = 0;
  int bad   = 0;

  // Model: stored entries as a queue, state as an integer 0..3.
  trace_entry_t mq[$];
  int           ms;
  int           mpost;
  int           mdrop;

  always #5 clk_i = ~clk_i;

  cve2_rvfi_trace_buffer #(.Depth(DEPTH), .PostTrigCount(PTC)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .arm_i(arm_i), .trig_i(trig_i), .trig_on_trap_i(trig_on_trap_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_entry_o(rd_entry_o),
    .state_o(state_o), .level_o(level_o), .dropped_o(dropped_o)
  );

  cve2_rvfi_trace_buffer #(.Depth(DEPTH), .PostTrigCount(0)) u_dut_p0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .arm_i(arm_i), .trig_i(trig_i), .trig_on_trap_i(trig_on_trap_i),
    .rd_valid_o(z_rd_valid), .rd_ready_i(rd_ready_i), .rd_entry_o(z_rd_entry),
    .state_o(z_state), .level_o(z_level), .dropped_o(z_dropped)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ms    = 0;
    mpost = 0;
    mdrop = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_update();
    trace_entry_t e;
    logic trg;
    e = '{order: rvfi_order[15:0], pc: rvfi_pc_rdata, insn: rvfi_insn,
          rd_addr: rvfi_rd_addr, rd_wdata: rvfi_rd_wdata, trap: rvfi_trap,
          intr: rvfi_intr, trig: 1'b0};
    if (!rst_ni) begin
      model_reset();
    end else if (arm_i) begin
      mq.delete();
      ms    = 1;
      mpost = 0;
      mdrop = 0;
    end else begin
      case (ms)
        1: begin
          trg = trig_i || (trig_on_trap_i && rvfi_valid && rvfi_trap);
          if (rvfi_valid) begin
            e.trig = trg;
            mq.push_back(e);
            if (mq.size() > DEPTH) void'(mq.pop_front());
          end
          if (trg) begin
            ms    = (PTC == 0) ? 3 : 2;
            mpost = 0;
          end
        end
        2: begin
          if (rvfi_valid) begin
            mq.push_back(e);
            if (mq.size() > DEPTH) void'(mq.pop_front());
            mpost++;
            if (mpost == PTC) ms = 3;
          end
        end
        default: begin
          if (rvfi_valid && mdrop < 65535) mdrop++;
          if (ms == 3 && rd_ready_i && mq.size() > 0) void'(mq.pop_front());
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock it, and update the model.
  task automatic cyc(input logic v, input logic [15:0] ord, input logic [31:0] pc,
                     input logic trap, input logic trg, input logic arm, input logic rdy);
    rvfi_valid    = v;
    rvfi_order    = {48'hA5A5_0000_C3C3, ord};
    rvfi_pc_rdata = pc;
    rvfi_insn     = pc ^ 32'h0000_0013;
    rvfi_rd_addr  = pc[6:2];
    rvfi_rd_wdata = ~pc;
    rvfi_intr     = ord[0];
    rvfi_trap     = trap;
    trig_i        = trg;
    arm_i         = arm;
    rd_ready_i    = rdy;
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic arm();
    cyc(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Every-cycle comparison of the main DUT against the model.
  always @(negedge clk_i) begin
    chk("state", state_o, ms[1:0]);
    chk("level", level_o, mq.size());
    chk("dropped", dropped_o, mdrop);
    chk("rd_valid", rd_valid_o, (ms == 3) && (mq.size() > 0));
    if (ms == 3 && mq.size() > 0) chk("rd_entry", rd_entry_o, mq[0]);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    trig_on_trap_i = 1'b0;
    model_reset();
    idle();
    idle();
    chk("rst_state", state_o, 2'd0);
    chk("rst_entry", rd_entry_o, 128'h0);
    rst_ni = 1'b1;
    idle();

    // Scenario 1: trigger on the 5th retirement, 8 post-trigger retirements.
    arm();
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(i), 32'h80 + 32'(4 * i), 1'b0, i == 4, 1'b0, 1'b0);
    chk("t1_state_post", state_o, 2'd2);
    for (int i = 5; i < 13; i++) cyc(1'b1, 16'(i), 32'h80 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_state", state_o, 2'd3);
    chk("t1_level", level_o, 5'd13);
    for (int i = 0; i < 13; i++) begin
      chk("t1_pc", rd_entry_o.pc, 32'h80 + 32'(4 * i));
      chk("t1_trig", rd_entry_o.trig, i == 4);
      cyc(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("t1_empty_valid", rd_valid_o, 1'b0);
    chk("t1_empty_state", state_o, 2'd3);

    // Scenario 2: ring overwrite, trap trigger at order 40.
    arm();
    trig_on_trap_i = 1'b1;
    for (int i = 0; i < 49; i++) cyc(1'b1, 16'(i), 32'h1000 + 32'(4 * i), i == 40, 1'b0, 1'b0, 1'b0);
    trig_on_trap_i = 1'b0;
    chk("t2_state", state_o, 2'd3);
    chk("t2_level", level_o, 5'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", rd_entry_o.order, 16'(33 + i));
      chk("t2_trig", rd_entry_o.trig, (33 + i) == 40);
      chk("t2_trap", rd_entry_o.trap, (33 + i) == 40);
      cyc(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, i[0]);
      if (!i[0]) cyc(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Scenario 3: zero post-trigger count freezes right after the trigger.
    arm();
    cyc(1'b1, 16'd100, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'd101, 32'h2004, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'd102, 32'h2008, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_p0_state", z_state, 2'd3);
    chk("t3_p0_level", z_level, 5'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_p0_valid", z_rd_valid, 1'b1);
      chk("t3_p0_order", z_rd_entry.order, 16'(100 + i));
      chk("t3_p0_trig", z_rd_entry.trig, i == 2);
      cyc(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("t3_p0_empty", z_rd_valid, 1'b0);

    // Scenario 4: saturate the drop counter while frozen.
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(103 + i), 32'h3000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_frozen", state_o, 2'd3);
    chk("t4_level0", level_o, 5'd11);
    for (int i = 0; i < 70000; i++) cyc(1'b1, 16'(i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_dropped", dropped_o, 16'hFFFF);
    chk("t4_level", level_o, 5'd11);

    // Scenario 5: arm beats retirement, trigger and pop in the same cycle.
    cyc(1'b1, 16'd7, 32'h4000, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_state", state_o, 2'd1);
    chk("t5_level", level_o, 5'd0);
    chk("t5_dropped", dropped_o, 16'd0);

    // Scenario 6: asynchronous reset in the middle of POST.
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'(i), 32'h5000 + 32'(4 * i), 1'b0, i == 4, 1'b0, 1'b0);
    chk("t6_state_post", state_o, 2'd2);
    chk("t6_level_pre", level_o, 5'd10);
    #3;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("t6_state", state_o, 2'd0);
    chk("t6_level", level_o, 5'd0);
    chk("t6_valid", rd_valid_o, 1'b0);
    chk("t6_dropped", dropped_o, 16'd0);
    chk("t6_entry", rd_entry_o, 128'h0);
    idle();
    rst_ni = 1'b1;
    cyc(1'b1, 16'd1, 32'h6000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_idle_drop", dropped_o, 16'd1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
